// File: rtl/key_event_pkg.sv
// Shared types for the key event classifier: FSM states, event codes and the
// counter width helper.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG_HELD,
    DEB_RELEASE,
    GAP
  } key_state_e;

  typedef enum logic [1:0] {
    EVT_NONE,
    EVT_SHORT,
    EVT_LONG,
    EVT_DOUBLE
  } key_evt_e;

  // Wide enough to hold the largest terminal count, with headroom for saturation.
  function automatic int calc_cnt_w(input int deb, input int hold, input int gap);
    int m;
    m = deb;
    if (hold > m) m = hold;
    if (gap > m) m = gap;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_event_fsm_if.sv
// Bundle between the edge detector stage (master) and the key event FSM (slave).
interface key_event_fsm_if;

  logic level_i;
  logic rise_i;
  logic fall_i;
  logic pressed_o;
  logic short_o;
  logic long_o;
  logic double_o;
  logic busy_o;

  modport master (
    output level_i, rise_i, fall_i,
    input  pressed_o, short_o, long_o, double_o, busy_o
  );

  modport slave (
    input  level_i, rise_i, fall_i,
    output pressed_o, short_o, long_o, double_o, busy_o
  );

endinterface

// File: rtl/sat_counter.sv
// Up counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/key_event_fsm.sv
// Debounces a push-button level and classifies presses as short, long or double.
// Double-press detection (GAP state) is built only when KEY_EVENT_DOUBLE_EN is defined.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int DOUBLE_GAP_CYCLES = 200
) (
  input logic            clk_i,
  input logic            rst_i,
  key_event_fsm_if.slave bus
);

  localparam int CNT_W = calc_cnt_w(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  key_state_e       state_q;
  key_evt_e         evt_q;
  logic             pressed_q;
  logic             from_long_q;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic             deb_clr, deb_en, hold_clr, hold_en;

`ifdef KEY_EVENT_DOUBLE_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  logic             second_q;
  logic [CNT_W-1:0] gap_cnt;
  logic             gap_run;
`endif

  // The gap timer keeps running through a second-press debounce so a glitch
  // can fall back into GAP without restarting the double-press window.
  always_comb begin
    deb_clr  = !(state_q inside {DEB_PRESS, DEB_RELEASE});
    deb_en   = ((state_q == DEB_PRESS) && bus.level_i) ||
               ((state_q == DEB_RELEASE) && !bus.level_i);
    hold_clr = (state_q == DEB_PRESS);
    hold_en  = (state_q == HELD) && bus.level_i && !bus.fall_i;
`ifdef KEY_EVENT_DOUBLE_EN
    gap_run  = (state_q == GAP) || ((state_q == DEB_PRESS) && second_q);
`endif
  end

  sat_counter #(.WIDTH(CNT_W)) u_deb_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clear(deb_clr), .enable(deb_en), .count(deb_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_hold_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clear(hold_clr), .enable(hold_en), .count(hold_cnt)
  );

`ifdef KEY_EVENT_DOUBLE_EN
  sat_counter #(.WIDTH(CNT_W)) u_gap_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clear(!gap_run), .enable(gap_run), .count(gap_cnt)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      evt_q       <= EVT_NONE;
      pressed_q   <= 1'b0;
      from_long_q <= 1'b0;
`ifdef KEY_EVENT_DOUBLE_EN
      second_q    <= 1'b0;
`endif
    end else begin
      evt_q <= EVT_NONE;
      case (state_q)
        IDLE: begin
          if (bus.rise_i) state_q <= DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!bus.level_i) begin
`ifdef KEY_EVENT_DOUBLE_EN
            state_q <= second_q ? GAP : IDLE;
`else
            state_q <= IDLE;
`endif
          end else if (deb_cnt == DEB_LAST) begin
            state_q     <= HELD;
            pressed_q   <= 1'b1;
            from_long_q <= 1'b0;
`ifdef KEY_EVENT_DOUBLE_EN
            if (second_q) evt_q <= EVT_DOUBLE;
`endif
          end
        end
        HELD: begin
          // A release in the threshold cycle wins: the key was not held that cycle.
          if (bus.fall_i || !bus.level_i) begin
            state_q <= DEB_RELEASE;
`ifdef KEY_EVENT_DOUBLE_EN
          end else if ((hold_cnt == LONG_LAST) && !second_q) begin
`else
          end else if (hold_cnt == LONG_LAST) begin
`endif
            state_q     <= LONG_HELD;
            from_long_q <= 1'b1;
            evt_q       <= EVT_LONG;
          end
        end
        LONG_HELD: begin
          if (bus.fall_i || !bus.level_i) state_q <= DEB_RELEASE;
        end
        DEB_RELEASE: begin
          if (bus.level_i) begin
            state_q <= from_long_q ? LONG_HELD : HELD;
          end else if (deb_cnt == DEB_LAST) begin
            pressed_q <= 1'b0;
            if (from_long_q) begin
              state_q <= IDLE;
`ifdef KEY_EVENT_DOUBLE_EN
            end else if (second_q) begin
              state_q  <= IDLE;
              second_q <= 1'b0;
            end else begin
              state_q <= GAP;
            end
`else
            end else begin
              state_q <= IDLE;
              evt_q   <= EVT_SHORT;
            end
`endif
          end
        end
`ifdef KEY_EVENT_DOUBLE_EN
        GAP: begin
          if (bus.rise_i) begin
            state_q  <= DEB_PRESS;
            second_q <= 1'b1;
          end else if (gap_cnt >= GAP_LAST) begin
            state_q  <= IDLE;
            second_q <= 1'b0;
            evt_q    <= EVT_SHORT;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pressed_o = pressed_q;
  assign bus.short_o   = (evt_q == EVT_SHORT);
  assign bus.long_o    = (evt_q == EVT_LONG);
  assign bus.busy_o    = (state_q != IDLE);
`ifdef KEY_EVENT_DOUBLE_EN
  assign bus.double_o  = (evt_q == EVT_DOUBLE);
`else
  assign bus.double_o  = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_fsm.sv
// Bench for key_event_fsm: directed and randomized press trains, each cycle's
// outputs compared against expectations derived from press/release timing.
module tb_key_event_fsm;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int MAXC = 8192;
  localparam int B_PRESSED = 4;
  localparam int B_SHORT   = 3;
  localparam int B_LONG    = 2;
  localparam int B_DOUBLE  = 1;
  localparam int B_BUSY    = 0;

  logic clk_i      = 1'b0;
  logic rst_i      = 1'b1;
  logic prev_level = 1'b0;

  key_event_fsm_if kif ();

  key_event_fsm #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .DOUBLE_GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (kif)
  );

  always #5 clk_i = ~clk_i;

  logic       stim_lvl [MAXC];
  logic       stim_rst [MAXC];
  logic [4:0] exp_vec  [MAXC];
  int         stim_tag [MAXC];
  string      tag_names [$];
  int         n_cyc = 0;
  int         pl [16];
  int         ql [16];
  int         np = 0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic open_segment(input string name, input int len);
    tag_names.push_back(name);
    for (int c = n_cyc; c < n_cyc + len; c++) begin
      stim_lvl[c] = 1'b0;
      stim_rst[c] = 1'b0;
      exp_vec[c]  = '0;
      stim_tag[c] = tag_names.size() - 1;
    end
  endtask

  task automatic mark(input int lo, input int hi, input int b);
    for (int c = lo; c < hi; c++) exp_vec[c][b] = 1'b1;
  endtask

  task automatic set_press(input int k, input int p, input int q);
    pl[k] = p;
    ql[k] = q;
    np    = k + 1;
  endtask

  // Press k is high for pl[k] cycles starting at its rise, then low for ql[k].
  // Acceptance lands DEB cycles after each edge; a short press waits out the
  // gap window only when double detection is built.
  task automatic build_presses(input string name);
    int r [16];
    int f [16];
    int t;
    int i;
    int base;
    base = n_cyc;
    t = base + 2;
    for (int k = 0; k < np; k++) begin
      r[k] = t;
      f[k] = t + pl[k];
      t    = f[k] + ql[k];
    end
    open_segment(name, t - base);
    for (int k = 0; k < np; k++) begin
      for (int c = r[k]; c < f[k]; c++) stim_lvl[c] = 1'b1;
      if (pl[k] > DEB) mark(r[k] + DEB, f[k] + DEB, B_PRESSED);
    end
    i = 0;
    while (i < np) begin
      if (pl[i] <= DEB) begin
        mark(r[i], f[i], B_BUSY);
        i++;
      end else if (pl[i] >= DEB + LONG + 1) begin
        mark(r[i] + DEB + LONG, r[i] + DEB + LONG + 1, B_LONG);
        mark(r[i], f[i] + DEB, B_BUSY);
        i++;
`ifdef KEY_EVENT_DOUBLE_EN
      end else if ((i + 1 < np) && (ql[i] <= DEB + GAP)) begin
        mark(r[i+1] + DEB, r[i+1] + DEB + 1, B_DOUBLE);
        mark(r[i], f[i+1] + DEB, B_BUSY);
        i += 2;
      end else begin
        mark(f[i] + DEB + GAP, f[i] + DEB + GAP + 1, B_SHORT);
        mark(r[i], f[i] + DEB + GAP, B_BUSY);
        i++;
      end
`else
      end else begin
        mark(f[i] + DEB, f[i] + DEB + 1, B_SHORT);
        mark(r[i], f[i] + DEB, B_BUSY);
        i++;
      end
`endif
    end
    n_cyc = t;
  endtask

  task automatic build_reset_idle(input int len);
    open_segment("reset_state", len);
    stim_rst[n_cyc]     = 1'b1;
    stim_rst[n_cyc + 1] = 1'b1;
    n_cyc += len;
  endtask

  // One-cycle reset while HELD; the key stays down well past the long threshold.
  task automatic build_reset_press();
    int r;
    int h;
    int len;
    r   = n_cyc + 2;
    h   = r + DEB + 3;
    len = 2 + 40 + DEB + 4;
    open_segment("reset_mid_held", len);
    for (int c = r; c < r + 40; c++) stim_lvl[c] = 1'b1;
    stim_rst[h] = 1'b1;
    mark(r + DEB, h, B_PRESSED);
    mark(r, h, B_BUSY);
    n_cyc += len;
  endtask

  task automatic applyStimulus(input int c);
    @(negedge clk_i);
    rst_i       = stim_rst[c];
    kif.level_i = stim_lvl[c];
    kif.rise_i  = stim_lvl[c] & ~prev_level;
    kif.fall_i  = ~stim_lvl[c] & prev_level;
    prev_level  = stim_lvl[c];
  endtask

  task automatic checkOutput(input int c);
    logic [4:0] obs;
    @(posedge clk_i);
    #1;
    obs = {kif.pressed_o, kif.short_o, kif.long_o, kif.double_o, kif.busy_o};
    vectors++;
    assert (obs === exp_vec[c]) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle %0d observed=%b expected=%b (pressed,short,long,double,busy)",
             tag_names[stim_tag[c]], c, obs, exp_vec[c]);
    end
  endtask

  initial begin
    kif.level_i = 1'b0;
    kif.rise_i  = 1'b0;
    kif.fall_i  = 1'b0;

    build_reset_idle(3);

    set_press(0, 8, 16);
    build_presses("clean_short");

    set_press(0, 2, 2);
    set_press(1, 30, 20);
    build_presses("bouncy_long");

    set_press(0, 6, DEB + 5);
    set_press(1, 6, 20);
    build_presses("double_mid_gap");

    set_press(0, 6, DEB + GAP);
    set_press(1, 6, 20);
    build_presses("double_at_gap_end");

    set_press(0, 6, DEB + GAP + 1);
    set_press(1, 6, 20);
    build_presses("rise_after_gap");

    set_press(0, DEB + LONG, 16);
    set_press(1, DEB + LONG + 1, 20);
    build_presses("long_threshold");

    set_press(0, DEB, 3);
    set_press(1, DEB + 1, 16);
    build_presses("debounce_edge");

    build_reset_press();

    for (int round = 0; round < 8; round++) begin
      for (int k = 0; k < 6; k++) begin
        set_press(k, int'($urandom_range(DEB + LONG + 6, DEB + 1)),
                     int'($urandom_range(DEB + GAP + 4, DEB + 1)));
      end
      ql[5] = DEB + GAP + 2 + int'($urandom_range(4, 0));
      build_presses("random_train");
    end

    $display("[TB] applying %0d cycles", n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      applyStimulus(c);
      checkOutput(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
